// File: rtl/sdc_latch_ctrl.sv
// ---------------------------------------------------------------------------
// sdc_latch_ctrl
//
// Clocked shutdown-circuit (SDC) relay latch controller.
//
// Each safety loop goes through a fail-fast / close-slow filter. A low sample
// clears a channel at once. A channel becomes OK again only after DEBOUNCE
// consecutive high samples. The controller qualifies TS activation with a hold
// time before it closes the relay. The activation source is the cockpit or the
// external button, selected by the AS driving mode. If a loop drops while the
// relay is closed, the controller latches the failing channels and stays in
// FAULT until it sees a valid acknowledge.
//
// Optional build macro: SDC_WATCHDOG_TOGGLE_EN
//   undefined : Watchdog is a level input, 1 = OK.
//   defined   : Watchdog must toggle. If WD_TIMEOUT cycles pass without an
//               edge, channel 0 fails. It recovers after the next edge plus
//               the debounce filter.
//
// Ports:
//   Clk                           in  system clock
//   Power_on_Reset                in  synchronous active-high reset
//   AS_close_SDC                  in  AS permission to close the SDC
//   AS_driving_mode               in  1 = external button, 0 = cockpit button
//   TS_Activation_Button_cockpit  in  raw cockpit button level
//   TS_Activation_Button_external in  raw external button level
//   Watchdog                      in  watchdog signal (gates safety channel 0)
//   Safety_ok[N_CHAN]             in  raw loop status, 1 = OK
//   Fault_clear                   in  single-cycle fault acknowledge
//   To_SDC_relais                 out relay drive (registered)
//   SDC_is_Ready                  out high while in READY (registered)
//   Fault_vector[N_CHAN]          out sticky channels that dropped while CLOSED
//   State[2]                      out 0 OPEN, 1 READY, 2 CLOSED, 3 FAULT
// ---------------------------------------------------------------------------
module sdc_latch_ctrl #(
    parameter int N_CHAN     = 2,
    parameter int DEBOUNCE   = 16,
    parameter int ACT_HOLD   = 8,
    parameter int WD_TIMEOUT = 1000
) (
    input  logic              Clk,
    input  logic              Power_on_Reset,
    input  logic              AS_close_SDC,
    input  logic              AS_driving_mode,
    input  logic              TS_Activation_Button_cockpit,
    input  logic              TS_Activation_Button_external,
    input  logic              Watchdog,
    input  logic [N_CHAN-1:0] Safety_ok,
    input  logic              Fault_clear,
    output logic              To_SDC_relais,
    output logic              SDC_is_Ready,
    output logic [N_CHAN-1:0] Fault_vector,
    output logic [1:0]        State
);

    // Reject parameter values that make the filter or hold logic meaningless.
    generate
        if (N_CHAN < 1 || N_CHAN > 16 || DEBOUNCE < 1 || ACT_HOLD < 1 || WD_TIMEOUT < 1) begin : g_param_check
            $error("sdc_latch_ctrl: parameter out of range");
        end
    endgenerate

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(ACT_HOLD + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACT_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_READY  = 2'd1,
        ST_CLOSED = 2'd2,
        ST_FAULT  = 2'd3
    } sdc_state_t;

    sdc_state_t          state_r;
    sdc_state_t          next_state_s;

    logic                wd_ok_s;
    logic [N_CHAN-1:0]   raw_s;
    logic [DB_W-1:0]     db_cnt_r [N_CHAN];
    logic [N_CHAN-1:0]   filt_r;
    logic                all_ok_s;

    logic                act_s;
    logic                mode_r;
    logic                mode_chg_s;
    logic                qual_s;
    logic [HOLD_W-1:0]   hold_r;
    logic [HOLD_W-1:0]   hold_nxt_s;
    logic                armed_r;
    logic                close_go_s;
    logic                close_edge_s;

    logic                relay_nxt_s;
    logic                ready_nxt_s;
    logic [N_CHAN-1:0]   fault_vec_nxt_s;

    // -----------------------------------------------------------------------
    // Watchdog qualification
    // -----------------------------------------------------------------------
`ifdef SDC_WATCHDOG_TOGGLE_EN
    localparam int WD_W = $clog2(WD_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic            wd_prev_r;
    logic [WD_W-1:0] wd_cnt_r;
    logic            wd_edge_s;

    assign wd_edge_s = Watchdog ^ wd_prev_r;

    // wd_cnt_r counts the edge-free cycles already seen. If the current
    // cycle is also edge-free and that completes WD_TIMEOUT cycles, the
    // channel fails in this same cycle.
    assign wd_ok_s = wd_edge_s | (wd_cnt_r < WD_LIM);

    // Watchdog edge tracker and saturating cycles-since-edge counter.
    always_ff @(posedge Clk) begin
        if (Power_on_Reset) begin
            wd_prev_r <= 1'b0;
            wd_cnt_r  <= '0;
        end else begin
            wd_prev_r <= Watchdog;
            if (wd_edge_s) begin
                wd_cnt_r <= '0;
            end else if (wd_cnt_r < WD_LIM) begin
                wd_cnt_r <= wd_cnt_r + WD_ONE;
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
        end
    end
`else
    assign wd_ok_s = Watchdog;
`endif

    // -----------------------------------------------------------------------
    // Per-channel fail-fast / close-slow filter
    // -----------------------------------------------------------------------

    // Channel 0 is valid only while the watchdog is also OK.
    always_comb begin
        raw_s    = Safety_ok;
        raw_s[0] = Safety_ok[0] & wd_ok_s;
    end

    // Count consecutive high samples per channel. A low sample clears the
    // count at once. The filtered bit rises on the DEBOUNCE-th high sample.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < N_CHAN; i++) begin
            if (Power_on_Reset) begin
                db_cnt_r[i] <= '0;
                filt_r[i]   <= 1'b0;
            end else if (!raw_s[i]) begin
                db_cnt_r[i] <= '0;
                filt_r[i]   <= 1'b0;
            end else if (db_cnt_r[i] != DB_MAX) begin
                db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                filt_r[i]   <= ((db_cnt_r[i] + DB_ONE) == DB_MAX);
            end else begin
                db_cnt_r[i] <= db_cnt_r[i];
                filt_r[i]   <= 1'b1;
            end
        end
    end

    assign all_ok_s = &filt_r;

    // -----------------------------------------------------------------------
    // Activation qualification
    // -----------------------------------------------------------------------
    assign act_s      = AS_driving_mode ? TS_Activation_Button_external
                                        : TS_Activation_Button_cockpit;
    assign mode_chg_s = AS_driving_mode ^ mode_r;

    // A cycle qualifies only if the mode is unchanged, so a mode switch in
    // the middle of a hold always restarts the hold.
    assign qual_s = (state_r == ST_READY) & act_s & AS_close_SDC & ~mode_chg_s;

    // Saturating hold counter value after this edge.
    always_comb begin
        if (!qual_s) begin
            hold_nxt_s = '0;
        end else if (hold_r == HOLD_MAX) begin
            hold_nxt_s = hold_r;
        end else begin
            hold_nxt_s = hold_r + HOLD_ONE;
        end
    end

    // The relay closes on the edge that completes the ACT_HOLD-th
    // qualifying cycle. The close latency is therefore ACT_HOLD edges.
    assign close_go_s   = qual_s & armed_r & (hold_nxt_s == HOLD_MAX);
    assign close_edge_s = (state_r == ST_READY) & (next_state_s == ST_CLOSED);

    // Hold counter, mode history and re-arm flag. The flag is disarmed by a
    // close and re-armed only after activation is seen low.
    always_ff @(posedge Clk) begin
        if (Power_on_Reset) begin
            hold_r  <= '0;
            mode_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            hold_r <= hold_nxt_s;
            mode_r <= AS_driving_mode;
            if (close_edge_s) begin
                armed_r <= 1'b0;
            end else if (!act_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Main FSM
    // -----------------------------------------------------------------------

    // State register and registered outputs, taken from the next state.
    always_ff @(posedge Clk) begin
        if (Power_on_Reset) begin
            state_r       <= ST_OPEN;
            To_SDC_relais <= 1'b0;
            SDC_is_Ready  <= 1'b0;
            Fault_vector  <= '0;
        end else begin
            state_r       <= next_state_s;
            To_SDC_relais <= relay_nxt_s;
            SDC_is_Ready  <= ready_nxt_s;
            Fault_vector  <= fault_vec_nxt_s;
        end
    end

    // Next-state logic. Within each state, the checks are in priority order.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_OPEN: begin
                if (all_ok_s) begin
                    next_state_s = ST_READY;
                end else begin
                    next_state_s = ST_OPEN;
                end
            end
            ST_READY: begin
                if (!all_ok_s) begin
                    next_state_s = ST_OPEN;
                end else if (close_go_s) begin
                    next_state_s = ST_CLOSED;
                end else begin
                    next_state_s = ST_READY;
                end
            end
            ST_CLOSED: begin
                // A loop fault takes precedence over a commanded open.
                if (!all_ok_s) begin
                    next_state_s = ST_FAULT;
                end else if (!AS_close_SDC) begin
                    next_state_s = ST_OPEN;
                end else begin
                    next_state_s = ST_CLOSED;
                end
            end
            ST_FAULT: begin
                if (Fault_clear && all_ok_s && !act_s) begin
                    next_state_s = ST_OPEN;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_OPEN;
            end
        endcase
    end

    // Output logic: next values for the relay, the ready flag and the
    // sticky fault vector.
    always_comb begin
        relay_nxt_s     = (next_state_s == ST_CLOSED);
        ready_nxt_s     = (next_state_s == ST_READY);
        fault_vec_nxt_s = Fault_vector;
        if ((state_r == ST_CLOSED) && (next_state_s == ST_FAULT)) begin
            fault_vec_nxt_s = Fault_vector | ~filt_r;
        end else if ((state_r == ST_FAULT) && (next_state_s == ST_OPEN)) begin
            fault_vec_nxt_s = '0;
        end else begin
            fault_vec_nxt_s = Fault_vector;
        end
    end

    assign State = state_r;

endmodule

// File: tb/tb_sdc_latch_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for sdc_latch_ctrl (default build, Watchdog as a level).
// A directed sequence follows the main scenarios. A randomized phase comes
// after it. A behavioural model runs on every edge, and the bench compares
// all outputs against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_sdc_latch_ctrl;

    localparam int N_CHAN     = 2;
    localparam int DEBOUNCE   = 16;
    localparam int ACT_HOLD   = 8;
    localparam int WD_TIMEOUT = 1000;

    logic              clk = 1'b0;
    logic              por;
    logic              as_close;
    logic              as_mode;
    logic              btn_cockpit;
    logic              btn_external;
    logic              wd;
    logic [N_CHAN-1:0] safety_ok;
    logic              fault_clear;
    logic              relay;
    logic              ready;
    logic [N_CHAN-1:0] fault_vec;
    logic [1:0]        state;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: the consecutive-high run length per channel, the length
    // of the current qualifying streak, and a plain integer SDC state.
    int                m_run [N_CHAN];
    int                m_streak;
    int                m_state;
    bit                m_armed;
    bit                m_prev_mode;
    logic [N_CHAN-1:0] m_fv;

    always #5 clk = ~clk;

    sdc_latch_ctrl #(
        .N_CHAN    (N_CHAN),
        .DEBOUNCE  (DEBOUNCE),
        .ACT_HOLD  (ACT_HOLD),
        .WD_TIMEOUT(WD_TIMEOUT)
    ) dut (
        .Clk                          (clk),
        .Power_on_Reset               (por),
        .AS_close_SDC                 (as_close),
        .AS_driving_mode              (as_mode),
        .TS_Activation_Button_cockpit (btn_cockpit),
        .TS_Activation_Button_external(btn_external),
        .Watchdog                     (wd),
        .Safety_ok                    (safety_ok),
        .Fault_clear                  (fault_clear),
        .To_SDC_relais                (relay),
        .SDC_is_Ready                 (ready),
        .Fault_vector                 (fault_vec),
        .State                        (state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge to the model, using the inputs as they stand now.
    task automatic model_step();
        bit act;
        bit all_ok;
        bit qual;
        bit go;
        int nxt;
        if (por) begin
            for (int i = 0; i < N_CHAN; i++) m_run[i] = 0;
            m_streak    = 0;
            m_state     = 0;
            m_armed     = 1'b0;
            m_prev_mode = 1'b0;
            m_fv        = '0;
            return;
        end
        act    = as_mode ? btn_external : btn_cockpit;
        all_ok = 1'b1;
        for (int i = 0; i < N_CHAN; i++) begin
            if (m_run[i] < DEBOUNCE) all_ok = 1'b0;
        end
        qual = (m_state == 1) && act && as_close && (as_mode == m_prev_mode);
        if (qual) m_streak = (m_streak < ACT_HOLD) ? m_streak + 1 : ACT_HOLD;
        else      m_streak = 0;
        go  = qual && m_armed && (m_streak >= ACT_HOLD);
        nxt = m_state;
        case (m_state)
            0: if (all_ok) nxt = 1;
            1: begin
                if (!all_ok) nxt = 0;
                else if (go) nxt = 2;
            end
            2: begin
                if (!all_ok) begin
                    nxt = 3;
                    for (int i = 0; i < N_CHAN; i++) begin
                        if (m_run[i] < DEBOUNCE) m_fv[i] = 1'b1;
                    end
                end else if (!as_close) begin
                    nxt = 0;
                end
            end
            3: begin
                if (fault_clear && all_ok && !act) begin
                    nxt  = 0;
                    m_fv = '0;
                end
            end
            default: nxt = 0;
        endcase
        if (m_state == 1 && nxt == 2) m_armed = 1'b0;
        else if (!act)                m_armed = 1'b1;
        for (int i = 0; i < N_CHAN; i++) begin
            if (safety_ok[i] && (i != 0 || wd)) m_run[i] = (m_run[i] < DEBOUNCE) ? m_run[i] + 1 : DEBOUNCE;
            else                                m_run[i] = 0;
        end
        m_prev_mode = as_mode;
        m_state     = nxt;
    endtask

    // Run n clock cycles. After each edge, compare the outputs with the model.
    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_val("state", {30'd0, state}, m_state);
            check_val("relay", {31'd0, relay}, (m_state == 2) ? 32'd1 : 32'd0);
            check_val("ready", {31'd0, ready}, (m_state == 1) ? 32'd1 : 32'd0);
            check_val("fault_vec", {30'd0, fault_vec}, {30'd0, m_fv});
        end
    endtask

    initial begin
        por          = 1'b1;
        as_close     = 1'b0;
        as_mode      = 1'b0;
        btn_cockpit  = 1'b0;
        btn_external = 1'b0;
        wd           = 1'b1;
        safety_ok    = 2'b00;
        fault_clear  = 1'b0;
        cycle(2);
        check_val("rst_state", {30'd0, state}, 32'd0);
        check_val("rst_relay", {31'd0, relay}, 32'd0);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_fv", {30'd0, fault_vec}, 32'd0);

        // Power-up into READY after the debounce period, then close.
        por = 1'b0; safety_ok = 2'b11; as_close = 1'b1;
        cycle(DEBOUNCE);
        check_val("pre_ready", {30'd0, state}, 32'd0);
        cycle(1);
        check_val("ready_state", {30'd0, state}, 32'd1);
        check_val("ready_out", {31'd0, ready}, 32'd1);
        btn_cockpit = 1'b1;
        cycle(ACT_HOLD - 1);
        check_val("hold_short", {31'd0, relay}, 32'd0);
        cycle(1);
        check_val("hold_close", {31'd0, relay}, 32'd1);
        check_val("closed_state", {30'd0, state}, 32'd2);

        // One-cycle drop on channel 1 while closed leads to FAULT.
        safety_ok = 2'b01; cycle(1);
        safety_ok = 2'b11; cycle(1);
        check_val("fault_relay", {31'd0, relay}, 32'd0);
        check_val("fault_state", {30'd0, state}, 32'd3);
        check_val("fault_vec10", {30'd0, fault_vec}, 32'd2);
        cycle(DEBOUNCE + 1);
        fault_clear = 1'b1; cycle(1); fault_clear = 1'b0;
        check_val("clr_btn_held", {30'd0, state}, 32'd3);
        btn_cockpit = 1'b0; cycle(1);
        check_val("fault_sticky", {30'd0, state}, 32'd3);
        fault_clear = 1'b1; cycle(1); fault_clear = 1'b0;
        check_val("clr_open", {30'd0, state}, 32'd0);
        check_val("clr_fv", {30'd0, fault_vec}, 32'd0);
        cycle(1);
        check_val("re_ready", {30'd0, state}, 32'd1);

        // External mode: the cockpit button is ignored and the external one closes.
        as_mode = 1'b1; btn_cockpit = 1'b1;
        cycle(20);
        check_val("cockpit_ignored", {30'd0, state}, 32'd1);
        btn_external = 1'b1;
        cycle(ACT_HOLD - 1);
        check_val("ext_short", {30'd0, state}, 32'd1);
        cycle(1);
        check_val("ext_close", {30'd0, state}, 32'd2);

        // Commanded open, then a held button must not re-close.
        as_close = 1'b0; cycle(1);
        check_val("cmd_open", {30'd0, state}, 32'd0);
        check_val("cmd_open_fv", {30'd0, fault_vec}, 32'd0);
        as_close = 1'b1; cycle(1);
        cycle(12);
        check_val("no_reclose", {30'd0, state}, 32'd1);
        btn_external = 1'b0; cycle(1);
        btn_external = 1'b1; cycle(ACT_HOLD - 1);
        check_val("rearm_short", {30'd0, state}, 32'd1);
        cycle(1);
        check_val("rearm_close", {30'd0, state}, 32'd2);

        // A mode flip in the middle of a hold restarts the count.
        as_close = 1'b0; cycle(1);
        as_close = 1'b1; btn_external = 1'b0; cycle(1);
        btn_external = 1'b1; cycle(4);
        as_mode = 1'b0; cycle(1);
        cycle(ACT_HOLD - 1);
        check_val("flip_restart", {30'd0, state}, 32'd1);
        cycle(1);
        check_val("flip_close", {30'd0, state}, 32'd2);

        // Reset while closed.
        por = 1'b1; cycle(1);
        check_val("por_relay", {31'd0, relay}, 32'd0);
        check_val("por_state", {30'd0, state}, 32'd0);
        check_val("por_ready", {31'd0, ready}, 32'd0);
        por = 1'b0; btn_cockpit = 1'b0;

        // A periodic glitch keeps the filter from ever qualifying.
        for (int k = 0; k < 10; k++) begin
            safety_ok = 2'b10; cycle(1);
            safety_ok = 2'b11; cycle(9);
            check_val("glitch_open", {30'd0, state}, 32'd0);
        end

        // Randomized phase.
        for (int k = 0; k < 4000; k++) begin
            por         = ($urandom_range(0, 799) == 0);
            safety_ok[0] = ($urandom_range(0, 199) != 0);
            safety_ok[1] = ($urandom_range(0, 199) != 0);
            wd          = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 11) == 0) btn_cockpit  = ~btn_cockpit;
            if ($urandom_range(0, 11) == 0) btn_external = ~btn_external;
            if ($urandom_range(0, 149) == 0) as_mode     = ~as_mode;
            if (as_close) as_close = ($urandom_range(0, 59) != 0);
            else          as_close = ($urandom_range(0, 4) == 0);
            fault_clear = ($urandom_range(0, 7) == 0);
            cycle(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sdc_latch_ctrl.md
Name: sdc_latch_ctrl

Overview:
- Clocked, parametrised successor of the shutdown-circuit (SDC) relay latch.
- Monitors N_CHAN safety loops (watchdog, shutdown loops, etc.) with a fail-fast / close-slow filter.
- Qualifies TS activation (cockpit or external, chosen by AS driving mode) with a hold time, drives the SDC relay and latches per-channel fault causes until explicitly cleared.
- Sits between the AS supervisor / cockpit buttons and the SDC relay driver.

Parameters:
- N_CHAN, 2, number of safety-loop inputs (1..16).
- DEBOUNCE, 16, cycles a channel must be continuously high before its filtered value rises (≥1).
- ACT_HOLD, 8, cycles activation and AS_close_SDC must both be held before the relay closes (≥1).
- WD_TIMEOUT, 1000, max cycles between Watchdog edges (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Power_on_Reset  in  1  synchronous, active-high reset.
- AS_close_SDC  in  1  AS permission to close SDC.
- AS_driving_mode  in  1  1 = external activation button, 0 = cockpit button.
- TS_Activation_Button_cockpit  in  1  raw button level.
- TS_Activation_Button_external  in  1  raw button level.
- Watchdog  in  1  watchdog signal; treated as safety channel 0.
- Safety_ok  in  N_CHAN  raw loop status, 1 = OK; bit 0 is ANDed with the Watchdog result.
- Fault_clear  in  1  single-cycle fault acknowledge.
- To_SDC_relais  out  1  relay drive, registered.
- SDC_is_Ready  out  1  high in READY, registered.
- Fault_vector  out  N_CHAN  latched channels that dropped while CLOSED.
- State  out  2  0 = OPEN, 1 = READY, 2 = CLOSED, 3 = FAULT.

Behaviour:
- Reset: State = OPEN, To_SDC_relais = 0, SDC_is_Ready = 0, Fault_vector = 0, all filters 0, counters 0. Reset mid-CLOSED opens the relay on the same edge.
- Filter, per channel:
  - Raw 0 → filtered 0 on the next edge (fail-fast).
  - Raw 1 → filtered 1 only after DEBOUNCE consecutive high cycles.
  - Any low sample restarts the count.
- All_ok = AND of filtered channels.
- Activation = AS_driving_mode ? external : cockpit.
- Hold counter:
  - Increments while State == READY, Activation = 1 and AS_close_SDC = 1; saturates at ACT_HOLD.
  - Clears on any other cycle and on any AS_driving_mode change.
- Armed flag:
  - Cleared when the relay closes.
  - Set only after Activation has been observed low.
  - A held button cannot re-close after an open.
- Transitions, evaluated every edge, priority top-down:
  - OPEN → READY when All_ok.
  - READY → OPEN when !All_ok.
  - READY → CLOSED when the hold counter reaches ACT_HOLD and armed = 1.
  - CLOSED → FAULT when !All_ok. Fault_vector |= bits whose filtered value is 0.
  - CLOSED → OPEN when AS_close_SDC = 0 (commanded open, no fault). If !All_ok and AS_close_SDC = 0 in the same cycle, FAULT wins.
  - FAULT → OPEN when Fault_clear = 1, All_ok = 1 and Activation = 0. Fault_vector clears on the same edge. Fault_clear in any other state or condition is ignored.
- Outputs are registered from the next state:
  - To_SDC_relais = (State == CLOSED).
  - Latency from a channel drop to relay low is exactly 1 cycle after the drop is sampled.
  - Close latency from the first qualifying READY cycle is ACT_HOLD cycles.
- Fault_vector is sticky; only reset or a valid clear zeroes it.

Optional Feature:
- Macro: SDC_WATCHDOG_TOGGLE_EN.
- Defined:
  - Watchdog must toggle; an edge detector and counter track it.
  - If WD_TIMEOUT cycles elapse without an edge, watchdog-OK drops (channel 0 fails fast).
  - It recovers only after the next edge plus the DEBOUNCE filter.
- Undefined: Watchdog is a level; 1 = OK.

Test Plan:
- Reset, N_CHAN = 2, Safety_ok = 11, Watchdog = 1 → READY after DEBOUNCE = 16 cycles. Hold cockpit button + AS_close_SDC for 8 cycles → To_SDC_relais = 1 on the 8th edge.
- In CLOSED, pulse Safety_ok[1] = 0 for one cycle → next edge: relay 0, State = 3, Fault_vector = 10. Fault_clear with button held → stays FAULT. Release button, then Fault_clear → OPEN, Fault_vector = 00.
- AS_driving_mode = 1, cockpit held 20 cycles → never closes. External held 8 cycles → closes. Mode flip mid-hold → counter restarts.
- CLOSED, AS_close_SDC → 0 → OPEN, Fault_vector = 00. Button still held after READY → no re-close until released and re-held 8 cycles.
- Safety_ok glitch 1-0-1 every 10 cycles → never reaches READY.
- Power_on_Reset asserted for 1 cycle in CLOSED → relay 0, all outputs 0 on that edge. With SDC_WATCHDOG_TOGGLE_EN and WD_TIMEOUT = 1000, a Watchdog stuck high in CLOSED → FAULT at cycle 1001, Fault_vector bit 0 set.
